// File: rtl/demux_4s_reg.sv
// demux_4s_reg: 1-to-16 registered demultiplexer with a two-entry
// (output stage + skid stage) elastic buffer. Words leave in accept
// order; each channel keeps its last delivered word on its o_k register.

// Per-channel output register: loads when its channel's word enters OS.
module demux_4s_reg_ch #(
   parameter int w = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld,
   input  logic [w-1:0] din,
   output logic [w-1:0] q
);
   // hold value until this channel is loaded again
   always_ff @(posedge clk or posedge rst)
      if (rst)     q <= '0;
      else if (ld) q <= din;
endmodule

module demux_4s_reg #(
   parameter int w = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [w-1:0] d,
   input  logic [3:0]   sel,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [w-1:0] o0,  o1,  o2,  o3,
   output logic [w-1:0] o4,  o5,  o6,  o7,
   output logic [w-1:0] o8,  o9,  o10, o11,
   output logic [w-1:0] o12, o13, o14, o15,
   output logic [15:0]  out_valid,
   input  logic [15:0]  out_ready
);
   typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

   typedef struct packed {
      logic [3:0]   sel;
      logic [w-1:0] d;
   } word_t;

   state_t state, state_nxt;
   word_t  os, sk, ld_w, in_w;
   logic   acc, dlv, os_ld, sk_ld, os_from_sk;
   logic [15:0][w-1:0] o_q;

   assign in_w = '{sel: sel, d: d};

   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= EMPTY;
      else     state <= state_nxt;

   // OS / SK payload registers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         os <= '0;
         sk <= '0;
      end else begin
         if (os_ld) os <= ld_w;
         if (sk_ld) sk <= in_w;
      end

   // next state, load controls and handshake outputs; in_ready comes from
   // registered state only so consumer ready never reaches the producer
   always_comb begin
      state_nxt  = state;
      os_ld      = 1'b0;
      sk_ld      = 1'b0;
      os_from_sk = 1'b0;
      in_ready   = (state != SKID);
      out_valid  = (state == EMPTY) ? 16'h0000 : (16'h0001 << os.sel);
      acc        = in_valid && in_ready;
      dlv        = (state != EMPTY) && out_ready[os.sel];
      case (state)
         EMPTY:
            if (acc) begin
               state_nxt = FULL;
               os_ld     = 1'b1;
            end
         FULL:
            if (acc && !dlv) begin
               state_nxt = SKID;
               sk_ld     = 1'b1;
            end else if (acc && dlv) begin
               os_ld     = 1'b1;
            end else if (dlv) begin
               state_nxt = EMPTY;
            end
         SKID:
            if (dlv) begin
               state_nxt  = FULL;
               os_ld      = 1'b1;
               os_from_sk = 1'b1;
            end
         default: state_nxt = EMPTY;
      endcase
      ld_w = os_from_sk ? sk : in_w;
   end

   // channel registers follow whatever enters OS
   for (genvar k = 0; k < 16; k++) begin : g_ch
      demux_4s_reg_ch #(.w(w)) u_ch (
         .clk (clk),
         .rst (rst),
         .ld  (os_ld && (ld_w.sel == 4'(k))),
         .din (ld_w.d),
         .q   (o_q[k])
      );
   end

   assign o0  = o_q[0];  assign o1  = o_q[1];  assign o2  = o_q[2];  assign o3  = o_q[3];
   assign o4  = o_q[4];  assign o5  = o_q[5];  assign o6  = o_q[6];  assign o7  = o_q[7];
   assign o8  = o_q[8];  assign o9  = o_q[9];  assign o10 = o_q[10]; assign o11 = o_q[11];
   assign o12 = o_q[12]; assign o13 = o_q[13]; assign o14 = o_q[14]; assign o15 = o_q[15];
endmodule

// File: tb/tb_demux_4s_reg.sv
// tb_demux_4s_reg: directed scenarios plus random traffic checked against
// a queue-based model of the two-entry in-order buffer.
module tb_demux_4s_reg;
   logic              clk = 1'b0;
   logic              rst;
   logic [15:0]       d;
   logic [3:0]        sel;
   logic              in_valid;
   logic              in_ready;
   logic [15:0][15:0] o;
   logic [15:0]       out_valid;
   logic [15:0]       out_ready;

   int nchk = 0;
   int nerr = 0;

   typedef struct packed {
      logic [3:0]  sel;
      logic [15:0] d;
   } wd_t;

   wd_t               q[$];
   logic [15:0][15:0] mo;

   demux_4s_reg #(.w(16)) dut (
      .clk(clk), .rst(rst), .d(d), .sel(sel), .in_valid(in_valid), .in_ready(in_ready),
      .o0(o[0]),   .o1(o[1]),   .o2(o[2]),   .o3(o[3]),
      .o4(o[4]),   .o5(o[5]),   .o6(o[6]),   .o7(o[7]),
      .o8(o[8]),   .o9(o[9]),   .o10(o[10]), .o11(o[11]),
      .o12(o[12]), .o13(o[13]), .o14(o[14]), .o15(o[15]),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_check();
      logic [15:0] exp_ov;
      exp_ov = (q.size() > 0) ? (16'h0001 << q[0].sel) : 16'h0000;
      chk("out_valid", {240'd0, out_valid}, {240'd0, exp_ov});
      chk("in_ready",  {255'd0, in_ready},  {255'd0, q.size() < 2});
      chk("o_all",     o,                   mo);
   endtask

   // one clock: decide accept/delivery from the model, advance it, then compare
   task automatic step();
      bit  acc, dlv, newhead;
      wd_t w;
      acc     = in_valid && (q.size() < 2);
      dlv     = (q.size() > 0) && out_ready[q[0].sel];
      w       = '{sel: sel, d: d};
      newhead = 0;
      @(posedge clk);
      if (dlv) begin
         void'(q.pop_front());
         newhead = (q.size() > 0);
      end
      if (acc) begin
         q.push_back(w);
         if (q.size() == 1) newhead = 1;
      end
      if (newhead) mo[q[0].sel] = q[0].d;
      #1;
      model_check();
   endtask

   task automatic put(input logic [15:0] dv, input logic [3:0] sv);
      in_valid = 1'b1; d = dv; sel = sv;
   endtask

   initial begin
      rst = 1'b1; d = '0; sel = '0; in_valid = 1'b0; out_ready = '0;
      q.delete(); mo = '0;
      #2;
      chk("rst_ov", {240'd0, out_valid}, 256'd0);
      chk("rst_ir", {255'd0, in_ready},  256'd1);
      chk("rst_o",  o,                   256'd0);
      @(negedge clk);
      rst = 1'b0;

      // single word
      out_ready = 16'hFFFF;
      put(16'hA5A5, 4'd3); step();
      chk("single_ov", {240'd0, out_valid}, {240'd0, 16'h0008});
      chk("single_o3", {240'd0, o[3]},      {240'd0, 16'hA5A5});
      in_valid = 1'b0; step();
      chk("single_ov2", {240'd0, out_valid}, 256'd0);
      chk("single_o3b", {240'd0, o[3]},      {240'd0, 16'hA5A5});

      // back-pressure into SKID, then release channel 2 only
      out_ready = 16'h0000;
      put(16'h1111, 4'd2); step();
      put(16'h2222, 4'd9); step();
      in_valid = 1'b0; step();
      chk("bp_ir", {255'd0, in_ready},  256'd0);
      chk("bp_ov", {240'd0, out_valid}, {240'd0, 16'h0004});
      out_ready = 16'h0004; step();
      chk("bp_ov2", {240'd0, out_valid}, {240'd0, 16'h0200});
      chk("bp_o9",  {240'd0, o[9]},      {240'd0, 16'h2222});
      chk("bp_ir2", {255'd0, in_ready},  256'd1);
      out_ready = 16'hFFFF; step();

      // full-rate streaming across all channels
      for (int k = 0; k < 16; k++) begin
         put(16'h0100 + 16'(k), 4'(k)); step();
         chk("stream_ov", {240'd0, out_valid}, {240'd0, 16'h0001 << k});
         chk("stream_ir", {255'd0, in_ready},  256'd1);
      end
      in_valid = 1'b0; step();
      for (int k = 0; k < 16; k++)
         chk("stream_o", {240'd0, o[k]}, {240'd0, 16'h0100 + 16'(k)});

      // ready on every channel except the one in OS
      out_ready = 16'h0000;
      put(16'h5555, 4'd5); step();
      in_valid = 1'b0; out_ready = 16'hFFDF; step(); step();
      chk("wrong_ov", {240'd0, out_valid}, {240'd0, 16'h0020});
      out_ready = 16'hFFFF; step();

      // async reset while SKID holds two words
      out_ready = 16'h0000;
      put(16'hC0C0, 4'd0); step();
      put(16'hC1C1, 4'd1); step();
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      q.delete(); mo = '0;
      chk("mid_rst_ov", {240'd0, out_valid}, 256'd0);
      chk("mid_rst_ir", {255'd0, in_ready},  256'd1);
      chk("mid_rst_o",  o,                   256'd0);
      @(negedge clk);
      rst = 1'b0; out_ready = 16'hFFFF;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_ov", {240'd0, out_valid}, 256'd0);
      end

      // same channel back-to-back
      put(16'h0001, 4'd7); step();
      chk("same_ov1", {240'd0, out_valid}, {240'd0, 16'h0080});
      chk("same_o7a", {240'd0, o[7]},      {240'd0, 16'h0001});
      put(16'h0002, 4'd7); step();
      chk("same_ov2", {240'd0, out_valid}, {240'd0, 16'h0080});
      chk("same_o7b", {240'd0, o[7]},      {240'd0, 16'h0002});
      in_valid = 1'b0; step();
      chk("same_ov3", {240'd0, out_valid}, 256'd0);

      // random traffic
      for (int i = 0; i < 2000; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         d        = 16'($urandom);
         sel      = 4'($urandom);
         case ($urandom_range(0, 3))
            0:       out_ready = 16'hFFFF;
            1:       out_ready = 16'h0000;
            default: out_ready = 16'($urandom);
         endcase
         step();
      end

      $display("CHECKS %0d ERRORS %0d", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/demux_4s_reg.md
DEMUX_4S_REG -- requirements
Module: demux_4s_reg

Interface
REQ-001 Parameter w, default 16, SHALL set the data width of the input word and of every channel output.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 d  input  w  SHALL be the data word to deliver.
REQ-005 sel  input  4  SHALL be the destination channel index, 0..15.
REQ-006 in_valid  input  1  SHALL mark d/sel as valid this cycle.
REQ-007 in_ready  output  1  SHALL mark that the block accepts d/sel this cycle.
REQ-008 o0..o15  output  w each  SHALL be the per-channel data registers.
REQ-009 out_valid  output  16  SHALL be a one-hot pending-delivery strobe; bit k belongs to channel k.
REQ-010 out_ready  input  16  SHALL be the per-channel consumer ready; bit k belongs to channel k.

Function
REQ-011 Accept SHALL occur on a rising edge where in_valid=1 and in_ready=1; it is the only event that captures d/sel.
REQ-012 Delivery on channel k SHALL occur on a rising edge where out_valid[k]=1 and out_ready[k]=1.
REQ-013 The block SHALL hold at most two words: an output stage (OS) and a skid stage (SK).
- State EMPTY: nothing held.
- State FULL: OS occupied.
- State SKID: OS and SK occupied.
REQ-014 in_ready SHALL be 1 in EMPTY and FULL and 0 in SKID; it SHALL decode from registered state only, with no combinational path from out_ready.
REQ-015 out_valid SHALL be all-zero in EMPTY; in FULL/SKID it SHALL have exactly bit OS.sel set.
REQ-016 Transitions SHALL be as follows (acc = accept, dlv = delivery of OS):
- EMPTY: acc -> FULL, OS loaded.
- FULL: acc and not dlv -> SKID, SK loaded.
- FULL: dlv and not acc -> EMPTY.
- FULL: acc and dlv -> FULL, OS loaded with the new word.
- FULL: neither -> FULL.
- SKID: dlv -> FULL, OS loaded from SK.
- SKID: no dlv -> SKID, no change.
REQ-017 Words SHALL be delivered in accept order, independent of channel index.
REQ-018 Latency from accept to out_valid assertion SHALL be exactly 1 cycle when the block is EMPTY, or when it is FULL and a delivery occurs in the same cycle.
REQ-019 When a word with sel=k is loaded into OS, o_k SHALL take that word on the same edge.
REQ-020 All other o_j SHALL hold their value; o_k SHALL also hold after delivery until channel k is loaded again.
REQ-021 out_ready bits other than bit OS.sel SHALL be ignored.
REQ-022 d and sel SHALL be ignored whenever no accept occurs.
REQ-023 Back-to-back words to the same channel SHALL each produce a separate out_valid pulse with its own o_k value.
REQ-024 Sustained throughput SHALL be one word per cycle while the destination holds out_ready high.

Reset
REQ-025 Asserting rst SHALL immediately, without waiting for clk, force:
- state EMPTY
- out_valid = 16'h0000
- in_ready = 1
- all o0..o15 = 0
- OS and SK contents discarded
REQ-026 Words held when rst asserts, including mid-delivery, SHALL be lost and never delivered.
REQ-027 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-028 The bench SHALL cover at least these directed scenarios:
- Single word: d=16'hA5A5, sel=3, out_ready=all 1 -> next cycle out_valid=16'h0008, o3=16'hA5A5; following cycle out_valid=0, o3 still A5A5.
- Back-pressure: accept 16'h1111 to sel=2 then 16'h2222 to sel=9, out_ready=0 -> state SKID, in_ready=0, out_valid=16'h0004. Raise out_ready[2] for one cycle -> out_valid=16'h0200, o9=16'h2222, in_ready=1.
- Full-rate streaming: 16 words d=16'h0100+k, sel=k, in_valid held high, out_ready all 1 -> out_valid walks 0x0001..0x8000 on consecutive cycles; every o_k=16'h0100+k; in_ready never drops.
- Wrong-channel ready: OS sel=5, out_ready=16'hFFDF -> no delivery, out_valid stays 16'h0020.
- Reset mid-operation: SKID holding sel 0 and sel 1, then assert rst between clock edges -> out_valid=0, in_ready=1, all o=0 immediately; neither word appears after release.
- Same-channel repeat: accept 16'h0001 then 16'h0002 to sel=7 with out_ready[7]=1 -> two consecutive out_valid=16'h0080 cycles; o7 shows 0001 then 0002.
